// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// mc_control : multi-cycle control FSM for the MIPS-subset datapath
// Revision   : 1.0
// ============================================================================
module mc_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_IF   = 4'd0;
  localparam logic [3:0] S_ID   = 4'd1;
  localparam logic [3:0] S_MADR = 4'd2;
  localparam logic [3:0] S_MRD  = 4'd3;
  localparam logic [3:0] S_MWB  = 4'd4;
  localparam logic [3:0] S_MWR  = 4'd5;
  localparam logic [3:0] S_REX  = 4'd6;
  localparam logic [3:0] S_RWB  = 4'd7;
  localparam logic [3:0] S_BEQ  = 4'd8;
  localparam logic [3:0] S_JMP  = 4'd9;
  localparam logic [3:0] S_IEX  = 4'd10;
  localparam logic [3:0] S_IWB  = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  logic [3:0] r_state;
  logic [3:0] w_next_state;
  logic [3:0] w_rtype_op;
  logic       w_funct_ok;
  logic       w_op_ok;
  logic       w_unused_zero;

  // The branch decision is the datapath's AND of pc_write_cond with zero.
  assign w_unused_zero = zero;
  assign state         = r_state;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IF;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_funct_ok = 1'b1;
    w_rtype_op = ALU_ADD;
    case (funct)
      6'h20:   w_rtype_op = ALU_ADD;
      6'h22:   w_rtype_op = ALU_SUB;
      6'h24:   w_rtype_op = ALU_AND;
      6'h25:   w_rtype_op = ALU_OR;
      6'h27:   w_rtype_op = ALU_NOR;
      6'h2A:   w_rtype_op = ALU_SLT;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_RTYPE:                     w_op_ok = w_funct_ok;
      OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI:                      w_op_ok = 1'b1;
      default:                      w_op_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = S_IF;
    case (r_state)
      S_IF: w_next_state = S_ID;
      S_ID: begin
        if (w_op_ok) begin
          case (opcode)
            OP_RTYPE:     w_next_state = S_REX;
            OP_LW, OP_SW: w_next_state = S_MADR;
            OP_BEQ:       w_next_state = S_BEQ;
            OP_J:         w_next_state = S_JMP;
            default:      w_next_state = S_IEX;
          endcase
        end
      end
      S_MADR:  w_next_state = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD:   w_next_state = S_MWB;
      S_REX:   w_next_state = S_RWB;
      S_IEX:   w_next_state = S_IWB;
      default: w_next_state = S_IF;
    endcase
  end

  // Reset low masks every strobe so an aborted instruction cannot commit.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    pc_source     = 2'b00;
    illegal       = 1'b0;
    if (reset) begin
      case (r_state)
        S_IF: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
        S_ID: begin
          alu_src_b = 2'b11;
          illegal   = ~w_op_ok;
        end
        S_MADR, S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_REX: begin
          alu_src_a = 1'b1;
          alu_op    = w_rtype_op;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          alu_op    = w_rtype_op;
        end
        S_IWB: reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
// tb_mc_control : instruction-level checks of the mc_control sequencer
// Revision      : 1.0
// ============================================================================
module tb_mc_control;

  logic       clock, reset, zero;
  logic [5:0] opcode, funct;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_op, state;

  mc_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal(illegal), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic [3:0] state;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         len;
    logic [3:0] ex;
    string      name;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  ctrl_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic ctrl_t dflt(input logic [3:0] s);
    ctrl_t c;
    c = '0;
    c.alu_op = 4'd2;
    c.state  = s;
    return c;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t c;
    c = '{pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
          reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, state};
    return c;
  endfunction

  function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h27: return 4'd12;
      default: return 4'd7;
    endcase
  endfunction

  // Reference: the micro-step list each instruction walks through.
  function automatic void build_expected(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    logic  legal;
    legal = (op inside {6'h23, 6'h2B, 6'h04, 6'h02, 6'h08}) ||
            (op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}));
    exp_q.delete();
    c = dflt(0); c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01;
    exp_q.push_back(c);
    c = dflt(1); c.alu_src_b = 2'b11; c.illegal = ~legal;
    exp_q.push_back(c);
    if (!legal) return;
    case (op)
      6'h00: begin
        c = dflt(6); c.alu_src_a = 1; c.alu_op = rtype_alu(fn); exp_q.push_back(c);
        c = dflt(7); c.reg_write = 1; c.reg_dst = 1; c.alu_op = rtype_alu(fn); exp_q.push_back(c);
      end
      6'h23, 6'h2B: begin
        c = dflt(2); c.alu_src_a = 1; c.alu_src_b = 2'b10; exp_q.push_back(c);
        if (op == 6'h23) begin
          c = dflt(3); c.mem_read = 1; c.iord = 1; exp_q.push_back(c);
          c = dflt(4); c.reg_write = 1; c.mem_to_reg = 1; exp_q.push_back(c);
        end else begin
          c = dflt(5); c.mem_write = 1; c.iord = 1; exp_q.push_back(c);
        end
      end
      6'h04: begin
        c = dflt(8); c.alu_src_a = 1; c.alu_op = 4'd6; c.pc_write_cond = 1;
        c.pc_source = 2'b01; exp_q.push_back(c);
      end
      6'h02: begin
        c = dflt(9); c.pc_write = 1; c.pc_source = 2'b10; exp_q.push_back(c);
      end
      default: begin
        c = dflt(10); c.alu_src_a = 1; c.alu_src_b = 2'b10; exp_q.push_back(c);
        c = dflt(11); c.reg_write = 1; exp_q.push_back(c);
      end
    endcase
  endfunction

  // Entered one time unit after a posedge with the DUT in IF; returns there.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input string tag, output int cycles, output logic [3:0] ex_alu);
    ctrl_t got;
    opcode = op; funct = fn; zero = z;
    build_expected(op, fn);
    #1;
    cycles = 0;
    ex_alu = 4'd2;
    for (int c = 0; c < 10; c++) begin
      got = sample();
      if (c < exp_q.size())
        check($sformatf("%s_c%0d", tag, c), 32'(got), 32'(exp_q[c]));
      if (got.state == 4'd6 || got.state == 4'd8) ex_alu = got.alu_op;
      @(posedge clock); #1;
      cycles++;
      if (state == 4'd0) break;
    end
    check({tag, "_len"}, 32'(cycles), 32'(exp_q.size()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[14];
    int         cyc;
    logic [3:0] ex;
    ctrl_t      got;
    logic [5:0] legal_fn[6];

    tbl[0]  = '{6'h23, 6'h00, 1'b0, 5, 4'd2,  "lw"};
    tbl[1]  = '{6'h2B, 6'h00, 1'b0, 4, 4'd2,  "sw"};
    tbl[2]  = '{6'h00, 6'h22, 1'b0, 4, 4'd6,  "sub"};
    tbl[3]  = '{6'h00, 6'h27, 1'b0, 4, 4'd12, "nor"};
    tbl[4]  = '{6'h00, 6'h2A, 1'b0, 4, 4'd7,  "slt"};
    tbl[5]  = '{6'h00, 6'h20, 1'b0, 4, 4'd2,  "add"};
    tbl[6]  = '{6'h00, 6'h24, 1'b0, 4, 4'd0,  "and"};
    tbl[7]  = '{6'h00, 6'h25, 1'b0, 4, 4'd1,  "or"};
    tbl[8]  = '{6'h08, 6'h00, 1'b0, 4, 4'd2,  "addi"};
    tbl[9]  = '{6'h04, 6'h00, 1'b1, 3, 4'd6,  "beq_z1"};
    tbl[10] = '{6'h04, 6'h00, 1'b0, 3, 4'd6,  "beq_z0"};
    tbl[11] = '{6'h02, 6'h00, 1'b0, 3, 4'd2,  "j"};
    tbl[12] = '{6'h3F, 6'h00, 1'b0, 2, 4'd2,  "ill_op"};
    tbl[13] = '{6'h00, 6'h03, 1'b0, 2, 4'd2,  "ill_fn"};
    legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    reset = 1'b0; opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check($sformatf("reset_c%0d", i), 32'(sample()), 32'(dflt(0)));
    end
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].name, cyc, ex);
      check({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].len));
      check({tbl[i].name, "_exalu"}, 32'(ex), 32'(tbl[i].ex));
    end

    // sw aborted by reset while in its memory-write state
    opcode = 6'h2B; funct = 6'h00;
    build_expected(6'h2B, 6'h00);
    #1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("swabort_c%0d", c), 32'(sample()), 32'(exp_q[c]));
      @(posedge clock); #1;
    end
    check("swabort_mwr", 32'(sample()), 32'(exp_q[3]));
    reset = 1'b0;
    #1;
    got = sample();
    got.state = 4'd0;
    check("swabort_masked", 32'(got), 32'(dflt(0)));
    @(posedge clock); #1;
    check("swabort_after", 32'(sample()), 32'(dflt(0)));
    reset = 1'b1;

    for (int i = 0; i < 60; i++) begin
      logic [5:0] op, fn;
      int k;
      k  = $urandom_range(0, 7);
      fn = 6'($urandom_range(0, 63));
      case (k)
        0: begin op = 6'h00; fn = legal_fn[$urandom_range(0, 5)]; end
        1: op = 6'h00;
        2: op = 6'h23;
        3: op = 6'h2B;
        4: op = 6'h04;
        5: op = 6'h02;
        6: op = 6'h08;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%h_fn%h", i, op, fn), cyc, ex);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control.md
# mc_control

Multi-cycle control unit for the MIPS-subset datapath built around the lab `ALU`, `RegFile` and `Memory` blocks. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath strobe and mux select, including the 4-bit ALU operation code, so it sits directly upstream of the ALU, register file and memory. The decoded instruction fields come back from the datapath instruction register.

## Interface
- No parameters; widths fixed to the 32-bit datapath.
- `clock`  in  1  single clock; state register updates on posedge.
- `reset`  in  1  synchronous, active-low; sampled on posedge.
- `opcode`  in  6  IR[31:26]; valid from ID onward.
- `funct`  in  6  IR[5:0]; valid from ID onward.
- `zero`  in  1  ALU zero flag (used in BEQ state).
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load qualified by `zero` (datapath ANDs).
- `iord`  out  1  memory address select: 0=PC, 1=ALUOut.
- `mem_read`  out  1  memory `ren`.
- `mem_write`  out  1  memory `wen`.
- `ir_write`  out  1  IR/MDR capture.
- `mem_to_reg`  out  1  write-back data: 0=ALUOut, 1=MDR.
- `reg_dst`  out  1  write address: 0=rt, 1=rd.
- `reg_write`  out  1  RegFile `wen`.
- `alu_src_a`  out  1  0=PC, 1=A reg.
- `alu_src_b`  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- `alu_op`  out  4  direct ALU op: 0 and, 1 or, 2 add, 6 sub, 7 slt, 12 nor.
- `pc_source`  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- `illegal`  out  1  one-cycle pulse in ID for an unsupported opcode/funct.
- `state`  out  4  current state code (debug/verification).

## Operation
- States and codes: IF=0, ID=1, MADR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, BEQ=8, JMP=9, IEX=10, IWB=11. Codes 12-15 go to IF on the next edge.
- Outputs are a Moore decode of `state`. Unlisted strobes are 0, selects are 0, and `alu_op` is 2.
- IF: `mem_read`, `ir_write`, `pc_write`; `alu_src_b`=01, `alu_op`=2. Next state is ID.
- ID: `alu_src_b`=11, `alu_op`=2 (branch target into ALUOut). Dispatch on `opcode`:
  - 0x00 -> REX
  - 0x23/0x2B -> MADR
  - 0x04 -> BEQ
  - 0x02 -> JMP
  - 0x08 -> IEX
  - anything else: `illegal`=1, next state IF.
- ID, R-type (opcode 0): a funct outside {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt} sets `illegal`=1 and goes to IF.
- MADR/IEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=2. MADR goes to MRD for lw, MWR for sw. IEX goes to IWB.
- MRD: `mem_read`, `iord`=1. Next state is MWB.
- MWB: `reg_write`, `mem_to_reg`=1, `reg_dst`=0. Next state is IF.
- MWR: `mem_write`, `iord`=1. Next state is IF.
- REX: `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x27->12, 0x2A->7. Next state is RWB.
- RWB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0. `alu_op` is held at the REX value. Next state is IF.
- IWB: `reg_write`, `reg_dst`=0, `mem_to_reg`=0. Next state is IF.
- BEQ: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=6, `pc_write_cond`, `pc_source`=01. Next state is IF.
- JMP: `pc_write`, `pc_source`=10. Next state is IF.
- `mem_read` and `mem_write` are never both 1 in any state, including illegal codes.

## Timing
- Reset:
  - While `reset`=0 at a posedge, `state` becomes IF.
  - While `reset` is low, all strobes (`pc_write`, `pc_write_cond`, `mem_read`, `mem_write`, `ir_write`, `reg_write`, `illegal`) are forced to 0, all selects to 0, and `alu_op` to 2.
  - The first IF cycle begins at the first posedge with `reset`=1.
- Reset asserted mid-instruction aborts it. No memory or register write is issued in the reset cycle.
- Instruction latency in cycles, IF through last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. An illegal instruction takes 2 (IF, ID).
- Strobes are stable for the full cycle from posedge. RegFile and Memory commit at the mid-cycle negedge, and the PC/IR registers at the closing posedge.
- `opcode`, `funct` and `zero` are sampled only combinationally within the current state. No input is registered.

## Test plan
- Reset held low for 3 cycles with `opcode`=0x2B -> `state`=0, `mem_write`=0, `reg_write`=0. First cycle after release shows `state`=0, `mem_read`=1, `ir_write`=1, `pc_write`=1, `alu_op`=2.
- lw (0x23) -> state sequence 0,1,2,3,4,0. `iord`=1 in state 3. State 4 has `reg_write`=1 and `mem_to_reg`=1. `mem_write` stays 0 throughout.
- R-type with funct 0x22, then 0x27, then 0x2A -> REX `alu_op` = 6, 12, 7 respectively. RWB has `reg_dst`=1 and `reg_write`=1. Each instruction takes 4 cycles.
- beq (0x04) with `zero`=1, then `zero`=0 -> state 8 shows `alu_op`=6, `pc_write_cond`=1, `pc_source`=01 in both cases. Return to IF after 3 cycles.
- opcode 0x3F, then opcode 0 with funct 0x03 -> `illegal`=1 for exactly the ID cycle, next state 0, no `reg_write` or `mem_write`.
- sw (0x2B) with reset dropped during state 5 -> `mem_write`=0 in that cycle, `state`=0 after the edge.
